// File: rtl/car_lane_renderer_pkg.sv
// Purpose: shared game constants, lane FSM state type and a modular-add helper.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package car_lane_renderer_pkg;

    localparam int SPRITE_W = 24;
    localparam int SCREEN_W = 640;
    localparam int WRAP     = SCREEN_W + SPRITE_W;

    typedef enum logic {
        STOP = 1'b0,
        RUN  = 1'b1
    } lane_state_t;

    // (a + b) mod WRAP, valid when both operands are already below WRAP
    function automatic logic [9:0] wrap_add(input logic [9:0] a, input logic [9:0] b);
        logic [10:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum >= 11'(WRAP)) begin
            sum = sum - 11'(WRAP);
        end
        return sum[9:0];
    endfunction

endpackage

// File: rtl/car_lane_renderer_car_hit_test.sv
// Purpose: hit test of one car sprite against the current pixel, with sprite-local offsets.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module car_hit_test
    import car_lane_renderer_pkg::*;
#(
    parameter logic [9:0] LANE_Y = 10'd216
) (
    input  logic [9:0] pos,
    input  logic [9:0] draw_x,
    input  logic [9:0] draw_y,
    output logic       hit,
    output logic [5:0] dx,
    output logic [5:0] dy
);

    logic [10:0] xs;
    logic [10:0] ys;
    logic [10:0] p;
    logic [10:0] ly;

    // pos is the sprite's right-shifted left edge, so compare against DrawX+24 to stay unsigned
    assign xs = {1'b0, draw_x} + 11'(SPRITE_W);
    assign ys = {1'b0, draw_y};
    assign p  = {1'b0, pos};
    assign ly = {1'b0, LANE_Y};

    assign hit = (p <= xs) && (xs < p + 11'(SPRITE_W)) &&
                 (ly <= ys) && (ys < ly + 11'(SPRITE_W));

    // offsets are forced to 0 off-sprite so the priority mux can pass them through blindly
    assign dx = hit ? 6'(xs - p) : 6'd0;
    assign dy = hit ? 6'(ys - ly) : 6'd0;

endmodule

// File: rtl/car_lane_renderer.sv
// Purpose: scrolls a lane of NUM_CARS cars and renders their sprite pixels via an external ROM.
// Latency: 2 Clk from DrawX/DrawY to pixel_on/pixel_idx; ROM address 1 Clk after DrawX/DrawY.
// Backpressure: none; free-running pixel pipeline, one pixel accepted every cycle.
module car_lane_renderer
    import car_lane_renderer_pkg::*;
#(
    parameter logic [9:0] LANE_Y   = 10'd216,
    parameter int         NUM_CARS = 3,
    parameter logic [9:0] SPACING  = 10'd220,
    parameter logic [9:0] START_X  = 10'd0
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_tick,
    input  logic       enable,
    input  logic [2:0] speed,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    output logic [5:0] rom_dx,
    output logic [5:0] rom_dy,
    input  logic [7:0] rom_data,
    output logic       pixel_on,
    output logic [7:0] pixel_idx
);

    lane_state_t          state;
    logic [9:0]           x0;
    logic [NUM_CARS-1:0]  car_hit;
    logic [5:0]           car_dx [NUM_CARS];
    logic [5:0]           car_dy [NUM_CARS];
    logic                 sel_hit;
    logic [5:0]           sel_dx;
    logic [5:0]           sel_dy;
    logic                 hit_q;

    // Lane FSM and base position; a tick moves the lane only if the state was already RUN
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= STOP;
            x0    <= START_X;
        end else begin
            if (state == RUN && frame_tick) begin
                x0 <= wrap_add(x0, {7'd0, speed});
            end
            state <= enable ? RUN : STOP;
        end
    end

    for (genvar i = 0; i < NUM_CARS; i++) begin : g_car
        // per-car offset folded into range at elaboration so the runtime add needs one wrap step
        localparam logic [9:0] OFFSET = 10'((i * int'(SPACING)) % WRAP);
        logic [9:0] pos;

        assign pos = wrap_add(x0, OFFSET);

        car_hit_test #(
            .LANE_Y (LANE_Y)
        ) u_hit (
            .pos    (pos),
            .draw_x (DrawX),
            .draw_y (DrawY),
            .hit    (car_hit[i]),
            .dx     (car_dx[i]),
            .dy     (car_dy[i])
        );
    end

    // Priority select: walk from the highest index down so the lowest-index car wins overlaps
    always_comb begin
        sel_hit = 1'b0;
        sel_dx  = 6'd0;
        sel_dy  = 6'd0;
        for (int i = NUM_CARS - 1; i >= 0; i--) begin
            if (car_hit[i]) begin
                sel_hit = 1'b1;
                sel_dx  = car_dx[i];
                sel_dy  = car_dy[i];
            end
        end
    end

    // Stage 1: present the ROM address and carry the hit flag alongside the ROM lookup
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rom_dx <= 6'd0;
            rom_dy <= 6'd0;
            hit_q  <= 1'b0;
        end else begin
            rom_dx <= sel_dx;
            rom_dy <= sel_dy;
            hit_q  <= sel_hit;
        end
    end

    // Stage 2: palette index 0 is transparent, so it never turns the pixel on
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            pixel_on  <= 1'b0;
            pixel_idx <= 8'd0;
        end else begin
            pixel_on  <= hit_q && (rom_data != 8'd0);
            pixel_idx <= (hit_q && (rom_data != 8'd0)) ? rom_data : 8'd0;
        end
    end

endmodule

// File: tb/tb_car_lane_renderer.sv
module tb_car_lane_renderer;

    localparam int LY = 216;
    localparam int NC = 3;
    localparam int SP = 220;
    localparam int SX = 0;
    localparam int WR = 664;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       frame_tick = 1'b0;
    logic       enable = 1'b0;
    logic [2:0] speed = 3'd0;
    logic [9:0] DrawX = 10'd0;
    logic [9:0] DrawY = 10'd0;
    logic [5:0] rom_dx;
    logic [5:0] rom_dy;
    logic [7:0] rom_data;
    logic       pixel_on;
    logic [7:0] pixel_idx;

    typedef struct {
        int         cyc;
        int         x;
        logic       hit;
        logic [5:0] dx;
        logic [5:0] dy;
        logic       on;
        logic [7:0] idx;
    } exp_t;

    exp_t s1q[$];
    exp_t s2q[$];
    int   ncmp = 0;
    int   nfail = 0;
    int   cyc = 0;
    int   lo_hits = 0;
    int   mx0 = SX;
    bit   m_run = 1'b0;
    int   saved;

    car_lane_renderer #(
        .LANE_Y   (10'(LY)),
        .NUM_CARS (NC),
        .SPACING  (10'(SP)),
        .START_X  (10'(SX))
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .frame_tick (frame_tick),
        .enable     (enable),
        .speed      (speed),
        .DrawX      (DrawX),
        .DrawY      (DrawY),
        .rom_dx     (rom_dx),
        .rom_dy     (rom_dy),
        .rom_data   (rom_data),
        .pixel_on   (pixel_on),
        .pixel_idx  (pixel_idx)
    );

    always #5 Clk = ~Clk;

    // sprite ROM stand-in: plenty of transparent (0) entries, (0,0)=0 and (4,9)=3
    function automatic logic [7:0] rom_f(input int dx, input int dy);
        return 8'((dx + 3 * dy) % 7);
    endfunction

    assign rom_data = rom_f(int'(rom_dx), int'(rom_dy));

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // reference: lane geometry straight from the screen rules, first car in index order wins
    function automatic exp_t predict(input int x0, input int x, input int y);
        exp_t e;
        e = '{default: 0};
        e.x = x;
        for (int i = 0; i < NC; i++) begin
            int pos;
            pos = (x0 + i * SP) % WR;
            if (!e.hit && pos <= x + 24 && x + 24 < pos + 24 && y >= LY && y < LY + 24) begin
                e.hit = 1'b1;
                e.dx  = 6'(x + 24 - pos);
                e.dy  = 6'(y - LY);
            end
        end
        e.idx = e.hit ? rom_f(int'(e.dx), int'(e.dy)) : 8'd0;
        e.on  = (e.idx != 8'd0);
        return e;
    endfunction

    task automatic step(input bit en, input bit tk, input int spd, input int x, input int y);
        exp_t e;
        enable     = en;
        frame_tick = tk;
        speed      = 3'(spd);
        DrawX      = 10'(x);
        DrawY      = 10'(y);
        e = predict(mx0, x, y);
        e.cyc = cyc;
        s1q.push_back(e);
        s2q.push_back(e);
        @(posedge Clk);
        if (m_run && tk) mx0 = (mx0 + spd) % WR;
        m_run = en;
        #1;
        chk("x0", 32'(dut.x0), 32'(mx0));
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        #1;
        chk("rst_pixel_on", 32'(pixel_on), 0);
        chk("rst_pixel_idx", 32'(pixel_idx), 0);
        chk("rst_rom_dx", 32'(rom_dx), 0);
        chk("rst_rom_dy", 32'(rom_dy), 0);
        chk("rst_x0", 32'(dut.x0), 32'(SX));
        s1q.delete();
        s2q.delete();
        mx0   = SX;
        m_run = 1'b0;
        @(posedge Clk);
        @(posedge Clk);
        #3 Reset = 1'b0;
        @(posedge Clk);
        #1;
    endtask

    // monitor: every cycle is an output beat; match each beat with the stimulus issued 1/2 cycles before
    always @(negedge Clk) begin
        if (!Reset) begin
            while (s1q.size() > 0 && s1q[0].cyc + 1 == cyc) begin
                exp_t e;
                e = s1q.pop_front();
                chk("hit_q", 32'(dut.hit_q), 32'(e.hit));
                chk("rom_dx", 32'(rom_dx), 32'(e.dx));
                chk("rom_dy", 32'(rom_dy), 32'(e.dy));
                if (e.x < 300 && dut.hit_q) lo_hits++;
            end
            while (s2q.size() > 0 && s2q[0].cyc + 2 == cyc) begin
                exp_t e;
                e = s2q.pop_front();
                chk("pixel_on", 32'(pixel_on), 32'(e.on));
                chk("pixel_idx", 32'(pixel_idx), 32'(e.idx));
            end
        end
    end

    initial begin
        #2;
        do_reset();

        // ten ticks at speed 2 from rest, then the reference pixel at DrawX=0
        step(1, 0, 2, 700, 0);
        for (int i = 0; i < 10; i++) step(1, 1, 2, 700, 0);
        chk("x0_after_10", 32'(dut.x0), 20);
        step(0, 0, 0, 0, LY + 9);
        chk("dir_rom_dx", 32'(rom_dx), 4);
        chk("dir_rom_dy", 32'(rom_dy), 9);
        step(0, 0, 0, 700, 0);
        chk("dir_pixel_on", 32'(pixel_on), 1);
        chk("dir_pixel_idx", 32'(pixel_idx), 3);
        step(0, 0, 0, 700, 0);

        // walk to 662, then one tick wraps to 0
        while (mx0 != 662) step(1, 1, 2, $urandom_range(0, 639), LY + $urandom_range(0, 23));
        step(1, 1, 2, 700, 0);
        chk("x0_wrap", 32'(dut.x0), 0);
        lo_hits = 0;
        for (int x = 0; x < 640; x++) step(0, 0, 0, x, LY + 5);
        step(0, 0, 0, 1000, 0);
        step(0, 0, 0, 1000, 0);
        chk("car1_visible_cols", 32'(lo_hits), 24);

        // disabled lane ignores ticks; enable falling with a tick still applies that tick
        saved = mx0;
        for (int i = 0; i < 5; i++) step(0, 1, 3, 700, 0);
        chk("x0_stopped", 32'(dut.x0), 32'(saved));
        step(1, 0, 3, 700, 0);
        step(0, 1, 3, 700, 0);
        chk("x0_fall_tick", 32'(dut.x0), 32'(saved + 3));
        step(0, 1, 3, 700, 0);
        chk("x0_after_fall", 32'(dut.x0), 32'(saved + 3));

        // transparent sprite corner of car1 (pos 223): dx=0, dy=0
        step(0, 0, 0, 199, LY);
        step(0, 0, 0, 700, 0);
        chk("transp_pixel_on", 32'(pixel_on), 0);
        chk("transp_pixel_idx", 32'(pixel_idx), 0);

        // rows just outside the lane
        for (int x = 0; x < 640; x++) step(0, 0, 0, x, LY + 24);
        for (int x = 0; x < 640; x++) step(0, 0, 0, x, LY - 1);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 7),
                 $urandom_range(0, 639), LY - 4 + $urandom_range(0, 32));
        end

        // reset mid-line while an opaque pixel is on screen at x0=300
        do_reset();
        step(1, 0, 6, 700, 0);
        for (int i = 0; i < 50; i++) step(1, 1, 6, 700, 0);
        chk("x0_300", 32'(dut.x0), 300);
        step(0, 0, 0, 280, LY + 9);
        step(0, 0, 0, 280, LY + 9);
        step(0, 0, 0, 280, LY + 9);
        chk("pre_rst_pixel_on", 32'(pixel_on), 1);
        do_reset();
        for (int i = 0; i < 200; i++) step(1, $urandom_range(0, 1), $urandom_range(0, 7),
                                           $urandom_range(0, 639), LY + $urandom_range(0, 23));

        repeat (3) @(posedge Clk);
        #1;
        chk("s1q_drained", 32'(s1q.size()), 0);
        chk("s2q_drained", 32'(s2q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
